// File: rtl/kypd_pkg.sv
// Shared definitions for the 4x4 keypad: the key-to-(row, col) lookup used by
// both the responder and the submission scanner, plus the responder state set.
package kypd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_B,
    HOLD,
    REL_B,
    GAP
  } state_t;

  // Zero-based: row 0 / col 0 correspond to ROW[1] / COL[1].
  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  function automatic key_pos_t key_pos(input logic [3:0] key);
    key_pos_t p;
    p = '0;
    case (key)
      4'h1: p = '{2'd0, 2'd0};
      4'h2: p = '{2'd0, 2'd1};
      4'h3: p = '{2'd0, 2'd2};
      4'hA: p = '{2'd0, 2'd3};
      4'h4: p = '{2'd1, 2'd0};
      4'h5: p = '{2'd1, 2'd1};
      4'h6: p = '{2'd1, 2'd2};
      4'hB: p = '{2'd1, 2'd3};
      4'h7: p = '{2'd2, 2'd0};
      4'h8: p = '{2'd2, 2'd1};
      4'h9: p = '{2'd2, 2'd2};
      4'hC: p = '{2'd2, 2'd3};
      4'h0: p = '{2'd3, 2'd0};
      4'hF: p = '{2'd3, 2'd1};
      4'hE: p = '{2'd3, 2'd2};
      4'hD: p = '{2'd3, 2'd3};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by every responder phase; done marks the last
// cycle of the loaded length (count at zero).
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               count <= '0;
    else if (load)           count <= value;
    else if (count != '0)    count <= count - W'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/keypad_responder.sv
// Keypad responder: accepts a key over valid/ready, plays a bounced press/hold/
// release contact profile and answers the scanner's column drive on ROW.
//
// state   | meaning
// IDLE    | ready for a key, contact open
// PRESS_B | press bounce: closed/open half-phases
// HOLD    | contact held closed
// REL_B   | release bounce: open/closed half-phases
// GAP     | contact open, next key not yet accepted
module keypad_responder
  import kypd_pkg::*;
#(
  parameter int HOLD_CYCLES   = 5000000,
  parameter int BOUNCE_PERIOD = 100000,
  parameter int BOUNCE_COUNT  = 4,
  parameter int GAP_CYCLES    = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [4:1] COL,
  output logic [4:1] ROW,
  output logic       contact,
  output logic       busy
);

  localparam int MAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_B = (BOUNCE_PERIOD > 2 * BOUNCE_COUNT) ? BOUNCE_PERIOD : 2 * BOUNCE_COUNT;
  localparam int CW    = $clog2((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1;
  localparam logic [CW-1:0] PH_LAST = CW'(2 * BOUNCE_COUNT - 1);

  if (BOUNCE_PERIOD < 1) begin : g_bad_period
    $error("keypad_responder: BOUNCE_PERIOD must be >= 1");
  end

  state_t        state, nxt_state;
  logic [3:0]    key_q;
  logic [CW-1:0] phase, t_value;
  logic          t_load, t_done;
  logic          accept, bounce, last_half, seg_end, half_step;
  key_pos_t      pos;
  logic [3:0]    row_mask, col_mask;

  // Nearest non-empty segment after s; zero-length segments are skipped.
  function automatic state_t next_after(input state_t s);
    state_t n;
    n = IDLE;
    if (GAP_CYCLES > 0 && s inside {IDLE, PRESS_B, HOLD, REL_B}) n = GAP;
    if (BOUNCE_COUNT > 0 && s inside {IDLE, PRESS_B, HOLD})      n = REL_B;
    if (HOLD_CYCLES > 0 && s inside {IDLE, PRESS_B})             n = HOLD;
    if (BOUNCE_COUNT > 0 && s == IDLE)                           n = PRESS_B;
    return n;
  endfunction

  function automatic logic [CW-1:0] seg_len(input state_t s);
    logic [CW-1:0] v;
    case (s)
      PRESS_B, REL_B: v = CW'(BOUNCE_PERIOD - 1);
      HOLD:           v = CW'(HOLD_CYCLES - 1);
      GAP:            v = CW'(GAP_CYCLES - 1);
      default:        v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    accept    = key_valid && key_ready;
    bounce    = (state == PRESS_B) || (state == REL_B);
    last_half = (phase == PH_LAST);
    seg_end   = (state != IDLE) && t_done && (!bounce || last_half);
    half_step = bounce && t_done && !last_half;
    nxt_state = next_after(state);
    t_load    = accept || seg_end || half_step;
    t_value   = half_step ? seg_len(PRESS_B) : seg_len(nxt_state);
    pos       = key_pos(key_q);
    row_mask  = 4'b0001 << pos.row;
    col_mask  = 4'b0001 << pos.col;
  end

  phase_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .value (t_value),
    .done  (t_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      key_ready <= 1'b1;
      contact   <= 1'b0;
      ROW       <= ROW_IDLE;
      key_q     <= '0;
      phase     <= '0;
    end else begin
      ROW <= (contact && ((COL & col_mask) == 4'b0000)) ? ~row_mask : ROW_IDLE;
      if (accept) key_q <= key_code;
      if (accept || seg_end) begin
        state     <= nxt_state;
        contact   <= (nxt_state inside {PRESS_B, HOLD});
        key_ready <= (nxt_state == IDLE);
        phase     <= '0;
      end else if (half_step) begin
        contact <= !contact;
        phase   <= phase + CW'(1);
      end
    end
  end

  assign busy = !key_ready;

endmodule
